elevador_cabine: RTL and testbench

//   Car/motor side of the elevator: consumes the controller's sobe/desce commands, moves the car one floor
//   per command with a fixed travel time, runs a timed door-open phase on arrival, and reports floor/status.

---
 rtl/elevador_pkg.sv | 21 ++
 rtl/elevador_temporizador.sv | 31 +++
 rtl/elevador_cabine.sv | 153 +++++++++++++++
 tb/tb_elevador_cabine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared encodings for the elevator: floor codes and car FSM states,
// common to the floor-request controller and the car.
package elevador_pkg;

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] S1   = 2'd1;
    localparam logic [1:0] S2   = 2'd2;
    localparam logic [1:0] S3   = 2'd3;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        PORTA    = 2'd3
    } cabine_estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevador_temporizador.sv
// Loadable down-counter that times car travel and the door phase.
// Saturates at zero; zero is flagged combinationally from the count register.
module elevador_temporizador #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    assign zero = (count_r == {WIDTH{1'b0}});

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (en && !zero) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/elevador_cabine.sv
// Elevator car: executes one-floor sobe/desce moves, times the door phase, reports floor/status.
// Optional CABINE_PORTA_SEGURA_EN adds porta_segura, which holds the door open while asserted.
module elevador_cabine
    import elevador_pkg::*;
#(
    parameter int N_ANDARES     = 3,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sobe,
    input  logic       desce,
`ifdef CABINE_PORTA_SEGURA_EN
    input  logic       porta_segura,
`endif
    output logic [1:0] andar,
    output logic       em_movimento,
    output logic       chegou,
    output logic       porta_aberta,
    output logic       erro
);

    localparam int TIMER_MAX = max_int(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [1:0]         ANDAR_TOPO  = 2'(N_ANDARES);

    cabine_estado_t      estado_r;
    cabine_estado_t      estado_next_s;
    logic [1:0]          andar_r;
    logic [1:0]          andar_next_s;
    logic                load_s;
    logic [TIMER_W-1:0]  load_val_s;
    logic                timer_en_s;
    logic                timer_zero_s;
    logic                erro_next_s;
    logic                em_movimento_next_s;
    logic                porta_aberta_next_s;
    logic                chegou_next_s;
    logic                em_movimento_r;
    logic                porta_aberta_r;
    logic                chegou_r;
    logic                erro_r;

    assign timer_en_s = (estado_r != PARADO);

    elevador_temporizador #(.WIDTH(TIMER_W)) u_temporizador (
        .clock (clock),
        .reset (reset),
        .load  (load_s),
        .en    (timer_en_s),
        .value (load_val_s),
        .zero  (timer_zero_s)
    );

    // State, floor and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r       <= PARADO;
            andar_r        <= S1;
            em_movimento_r <= 1'b0;
            porta_aberta_r <= 1'b0;
            chegou_r       <= 1'b0;
            erro_r         <= 1'b0;
        end else begin
            estado_r       <= estado_next_s;
            andar_r        <= andar_next_s;
            em_movimento_r <= em_movimento_next_s;
            porta_aberta_r <= porta_aberta_next_s;
            chegou_r       <= chegou_next_s;
            erro_r         <= erro_next_s;
        end
    end

    // Next state, next floor and timer reloads; commands only matter in PARADO.
    always_comb begin
        estado_next_s = estado_r;
        andar_next_s  = andar_r;
        load_s        = 1'b0;
        load_val_s    = TRAVEL_LOAD;
        erro_next_s   = 1'b0;
        case (estado_r)
            PARADO: begin
                if (sobe && desce) begin
                    erro_next_s = 1'b1;
                end else if (sobe && (andar_r < ANDAR_TOPO)) begin
                    estado_next_s = SUBINDO;
                    load_s        = 1'b1;
                end else if (desce && (andar_r > S1)) begin
                    estado_next_s = DESCENDO;
                    load_s        = 1'b1;
                end else if (sobe || desce) begin
                    erro_next_s = 1'b1;
                end else begin
                    estado_next_s = PARADO;
                end
            end
            SUBINDO, DESCENDO: begin
                if (timer_zero_s) begin
                    if ((estado_r == SUBINDO) && (andar_r < ANDAR_TOPO)) begin
                        andar_next_s = andar_r + 2'd1;
                    end else if ((estado_r == DESCENDO) && (andar_r > S1)) begin
                        andar_next_s = andar_r - 2'd1;
                    end else begin
                        andar_next_s = andar_r;
                    end
                    estado_next_s = PORTA;
                    load_s        = 1'b1;
                    load_val_s    = DOOR_LOAD;
                end else begin
                    estado_next_s = estado_r;
                end
            end
            PORTA: begin
`ifdef CABINE_PORTA_SEGURA_EN
                if (porta_segura) begin
                    load_s     = 1'b1;
                    load_val_s = DOOR_LOAD;
                end else if (timer_zero_s) begin
                    estado_next_s = PARADO;
                end else begin
                    estado_next_s = PORTA;
                end
`else
                if (timer_zero_s) begin
                    estado_next_s = PARADO;
                end else begin
                    estado_next_s = PORTA;
                end
`endif
            end
            default: begin
                estado_next_s = PARADO;
            end
        endcase
    end

    // Output values are derived from the upcoming state so they register alongside it.
    always_comb begin
        em_movimento_next_s = (estado_next_s == SUBINDO) || (estado_next_s == DESCENDO);
        porta_aberta_next_s = (estado_next_s == PORTA);
        chegou_next_s       = (andar_next_s != andar_r);
    end

    assign andar        = andar_r;
    assign em_movimento = em_movimento_r;
    assign chegou       = chegou_r;
    assign porta_aberta = porta_aberta_r;
    assign erro         = erro_r;

endmodule

// File: tb/tb_elevador_cabine.sv
// Directed self-checking bench for elevador_cabine (TRAVEL_CYCLES=8, DOOR_CYCLES=4).
// Define CABINE_PORTA_SEGURA_EN to also exercise the door-hold input.
module tb_elevador_cabine;

    logic       clock;
    logic       reset;
    logic       sobe;
    logic       desce;
`ifdef CABINE_PORTA_SEGURA_EN
    logic       porta_segura;
`endif
    logic [1:0] andar;
    logic       em_movimento;
    logic       chegou;
    logic       porta_aberta;
    logic       erro;

    int total_cnt;
    int bad_cnt;

    elevador_cabine #(
        .N_ANDARES     (3),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sobe         (sobe),
        .desce        (desce),
`ifdef CABINE_PORTA_SEGURA_EN
        .porta_segura (porta_segura),
`endif
        .andar        (andar),
        .em_movimento (em_movimento),
        .chegou       (chegou),
        .porta_aberta (porta_aberta),
        .erro         (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] a, input logic m,
                                input logic c, input logic p, input logic e);
        check({tag, ".andar"}, {30'd0, andar}, {30'd0, a});
        check({tag, ".em_movimento"}, {31'd0, em_movimento}, {31'd0, m});
        check({tag, ".chegou"}, {31'd0, chegou}, {31'd0, c});
        check({tag, ".porta_aberta"}, {31'd0, porta_aberta}, {31'd0, p});
        check({tag, ".erro"}, {31'd0, erro}, {31'd0, e});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        sobe      = 1'b0;
        desce     = 1'b0;
`ifdef CABINE_PORTA_SEGURA_EN
        porta_segura = 1'b0;
`endif
        #2;
        do_reset();
        check_status("reset", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: single sobe pulse from floor 1
        sobe = 1'b1;
        ticks(1);
        sobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_status("t1.travel", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            ticks(1);
        end
        check_status("t1.arrive", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            check_status("t1.door", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        ticks(1);
        check_status("t1.parado", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        check_status("t1.idle", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: sobe held from floor 1 climbs to 3, then errors each PARADO cycle
        do_reset();
        sobe = 1'b1;
        ticks(9);
        check_status("t2.s2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(4);
        check_status("t2.parado2", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_status("t2.restart", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        check_status("t2.travel", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_status("t2.s3", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(4);
        check_status("t2.parado3", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_status("t2.erro1", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check_status("t2.erro2", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        sobe = 1'b0;
        ticks(1);
        check_status("t2.clear", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: desce at floor 1, then both commands together
        do_reset();
        desce = 1'b1;
        ticks(1);
        check_status("t3.desce_s1", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        desce = 1'b0;
        ticks(1);
        check_status("t3.gap", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        sobe  = 1'b1;
        desce = 1'b1;
        ticks(1);
        check_status("t3.both", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        sobe  = 1'b0;
        desce = 1'b0;
        ticks(1);
        check_status("t3.after", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: desce mid-travel of a sobe move is ignored
        sobe = 1'b1;
        ticks(1);
        sobe = 1'b0;
        ticks(3);
        desce = 1'b1;
        ticks(4);
        check_status("t4.travel", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_status("t4.arrive", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        desce = 1'b0;
        ticks(4);
        check_status("t4.parado", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: reset at travel cycle 5 from floor 2
        sobe = 1'b1;
        ticks(1);
        sobe = 1'b0;
        ticks(4);
        check_status("t5.travel", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        ticks(1);
        check_status("t5.reset", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        ticks(8);
        check_status("t5.lost", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CABINE_PORTA_SEGURA_EN
        // 6: porta_segura held during PORTA keeps door open until 4 cycles after release
        do_reset();
        sobe = 1'b1;
        ticks(1);
        sobe = 1'b0;
        ticks(8);
        check_status("t6.arrive", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        porta_segura = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            check_status("t6.hold", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        porta_segura = 1'b0;
        ticks(3);
        check_status("t6.release", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        check_status("t6.closed", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
